// File: rtl/sccomp_pkg.sv
// Shared types and constants for the single-cycle CPU memory bridge.
// Base addresses follow the MARS memory map.
package sccomp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_t;

  localparam logic [31:0] TEXT_BASE = 32'h0040_0000;
  localparam logic [31:0] DATA_BASE = 32'h1001_0000;
  localparam logic [31:0] MMIO_BASE = 32'hFFFF_0000;
  localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

  // Wrap-safe region test: addresses below base wrap high and miss.
  function automatic logic in_region(input logic [31:0] addr, input logic [31:0] base,
                                     input logic [31:0] bytes);
    logic [31:0] off;
    off = addr - base;
    return off < bytes;
  endfunction

endpackage

// File: rtl/sccomp_addr_decode.sv
// Combinational decode of a MARS data address into dmem / MMIO hits and word indices.
// Hits ignore alignment; the caller combines them with the misaligned flag.
module sccomp_addr_decode
  import sccomp_pkg::*;
#(
  parameter logic [31:0] DATA_BASE  = sccomp_pkg::DATA_BASE,
  parameter int          DMEM_WORDS = 2048,
  parameter logic [31:0] MMIO_BASE  = sccomp_pkg::MMIO_BASE,
  parameter int          MMIO_WORDS = 64,
  localparam int         DA_W       = $clog2(DMEM_WORDS),
  localparam int         MA_W       = $clog2(MMIO_WORDS)
) (
  input  logic [31:0]     addr,
  output logic            hit_dmem,
  output logic            hit_mmio,
  output logic            misaligned,
  output logic [DA_W-1:0] dmem_idx,
  output logic [MA_W-1:0] mmio_idx
);

  localparam logic [31:0] DMEM_BYTES = 32'(4 * DMEM_WORDS);
  localparam logic [31:0] MMIO_BYTES = 32'(4 * MMIO_WORDS);

  logic [31:0] off_dmem;
  logic [31:0] off_mmio;

  assign off_dmem   = addr - DATA_BASE;
  assign off_mmio   = addr - MMIO_BASE;
  assign hit_dmem   = in_region(addr, DATA_BASE, DMEM_BYTES);
  assign hit_mmio   = in_region(addr, MMIO_BASE, MMIO_BYTES);
  assign misaligned = (addr[1:0] != 2'b00);
  assign dmem_idx   = DA_W'(off_dmem >> 2);
  assign mmio_idx   = MA_W'(off_mmio >> 2);

endmodule

// File: rtl/sccomp_mem_bridge.sv
// Memory bridge: combinational instruction fetch plus a stalling req/ack data path
// to dmem and MMIO, with a sticky bus error for unmapped, misaligned or timed-out accesses.
module sccomp_mem_bridge
  import sccomp_pkg::*;
#(
  parameter int          DATA_W     = 32,
  parameter logic [31:0] TEXT_BASE  = sccomp_pkg::TEXT_BASE,
  parameter logic [31:0] DATA_BASE  = sccomp_pkg::DATA_BASE,
  parameter int          DMEM_WORDS = 2048,
  parameter logic [31:0] MMIO_BASE  = sccomp_pkg::MMIO_BASE,
  parameter int          MMIO_WORDS = 64,
  parameter int          TIMEOUT    = 15,
  localparam int         BE_W       = DATA_W / 8,
  localparam int         DA_W       = $clog2(DMEM_WORDS),
  localparam int         MA_W       = $clog2(MMIO_WORDS)
) (
  input  logic              clk_in,
  input  logic              reset_n,
  // instruction fetch
  input  logic [31:0]       cpu_pc,
  output logic [DATA_W-1:0] cpu_inst,
  output logic [31:0]       imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  // CPU data port
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [31:0]       cpu_addr,
  input  logic [BE_W-1:0]   cpu_be,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  // dmem target
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [DA_W-1:0]   dmem_addr,
  output logic [BE_W-1:0]   dmem_be,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic              dmem_ack,
  input  logic [DATA_W-1:0] dmem_rdata,
  // MMIO target
  output logic              mmio_req,
  output logic              mmio_we,
  output logic [MA_W-1:0]   mmio_addr,
  output logic [BE_W-1:0]   mmio_be,
  output logic [DATA_W-1:0] mmio_wdata,
  input  logic              mmio_ack,
  input  logic [DATA_W-1:0] mmio_rdata,
  // status
  output logic              bus_err,
  output logic [31:0]       err_addr,
  output state_t            fsm_state
);

  // Handshake: cpu_req is held with stable addr/be/wdata/we until cpu_stall is low
  // in a cycle; each target gets a one-cycle *_req strobe and answers with a one-cycle
  // *_ack carrying rdata. Acks outside WAIT are ignored.

  localparam int                CNT_W    = ($clog2(TIMEOUT + 1) < 4) ? 4 : $clog2(TIMEOUT + 1);
  localparam logic [DATA_W-1:0] ERR_WORD = DATA_W'(ERR_RDATA);

  state_t state, state_nx;

  logic            hit_dmem, hit_mmio, misaligned;
  logic [DA_W-1:0] dec_dmem_idx;
  logic [MA_W-1:0] dec_mmio_idx;
  logic            decode_ok;

  logic [31:0]       addr_q;
  logic [BE_W-1:0]   be_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q;
  logic              mmio_sel_q;
  logic [DA_W-1:0]   dmem_idx_q;
  logic [MA_W-1:0]   mmio_idx_q;
  logic [CNT_W-1:0]  cnt;

  logic              ack;
  logic [DATA_W-1:0] tgt_rdata;
  logic              timeout_hit;
  logic [31:0]       pc_off;

  // Fetch path: never stalled, purely combinational.
  assign pc_off    = cpu_pc - TEXT_BASE;
  assign imem_addr = pc_off >> 2;
  assign cpu_inst  = imem_rdata;

  sccomp_addr_decode #(
    .DATA_BASE (DATA_BASE),
    .DMEM_WORDS(DMEM_WORDS),
    .MMIO_BASE (MMIO_BASE),
    .MMIO_WORDS(MMIO_WORDS)
  ) u_decode (
    .addr      (cpu_addr),
    .hit_dmem  (hit_dmem),
    .hit_mmio  (hit_mmio),
    .misaligned(misaligned),
    .dmem_idx  (dec_dmem_idx),
    .mmio_idx  (dec_mmio_idx)
  );

  assign decode_ok   = ~misaligned & (hit_dmem | hit_mmio);
  assign ack         = mmio_sel_q ? mmio_ack : dmem_ack;
  assign tgt_rdata   = mmio_sel_q ? mmio_rdata : dmem_rdata;
  assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (cpu_req) state_nx = decode_ok ? WAIT : ERR;
      WAIT: begin
        // Ack is checked first so it wins over a simultaneous timeout.
        if (ack)              state_nx = DONE;
        else if (timeout_hit) state_nx = ERR;
      end
      DONE:    state_nx = IDLE;
      ERR:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    cpu_stall = 1'b0;
    dmem_req  = 1'b0;
    mmio_req  = 1'b0;
    case (state)
      IDLE: cpu_stall = cpu_req;
      WAIT: begin
        cpu_stall = 1'b1;
        dmem_req  = (cnt == '0) & ~mmio_sel_q;
        mmio_req  = (cnt == '0) & mmio_sel_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      addr_q     <= '0;
      be_q       <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      mmio_sel_q <= 1'b0;
      dmem_idx_q <= '0;
      mmio_idx_q <= '0;
      cnt        <= '0;
      cpu_rdata  <= '0;
      bus_err    <= 1'b0;
      err_addr   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req && decode_ok) begin
            addr_q     <= cpu_addr;
            be_q       <= cpu_be;
            wdata_q    <= cpu_wdata;
            we_q       <= cpu_we;
            mmio_sel_q <= hit_mmio;
            dmem_idx_q <= dec_dmem_idx;
            mmio_idx_q <= dec_mmio_idx;
            cnt        <= '0;
          end else if (cpu_req) begin
            bus_err <= 1'b1;
            if (!bus_err) err_addr  <= cpu_addr;
            if (!cpu_we)  cpu_rdata <= ERR_WORD;
          end
        end
        WAIT: begin
          if (ack) begin
            if (!we_q) cpu_rdata <= tgt_rdata;
          end else if (timeout_hit) begin
            bus_err <= 1'b1;
            if (!bus_err) err_addr  <= addr_q;
            if (!we_q)    cpu_rdata <= ERR_WORD;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign dmem_we    = we_q;
  assign dmem_addr  = dmem_idx_q;
  assign dmem_be    = be_q;
  assign dmem_wdata = wdata_q;
  assign mmio_we    = we_q;
  assign mmio_addr  = mmio_idx_q;
  assign mmio_be    = be_q;
  assign mmio_wdata = wdata_q;
  assign fsm_state  = state;

endmodule
